// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: register file, TLB writes, PC redirects and the exception lock.
// Optional per-thread retired-instruction counters are enabled with `define WB_RETIRE_CNT_EN.
module wb_commit_unit #(
   parameter int N_THREADS = 4,
   parameter int XLEN      = 32,
   parameter int REG_AW    = 5,
   parameter int VPN_W     = 20,
   parameter int PPN_W     = 8,
   parameter logic [XLEN-1:0] BOOT_PC = 32'h1000,
   parameter logic [XLEN-1:0] EXC_PC  = 32'h2000,
   localparam int TID_W = $clog2(N_THREADS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_present,
   input  logic [TID_W-1:0]                 in_thread,
   input  logic                             in_ok,
   input  logic                             in_itlb_miss,
   input  logic                             in_dtlb_miss,
   input  logic [XLEN-1:0]                  in_pc,
   input  logic [REG_AW-1:0]                in_dst,
   input  logic [XLEN-1:0]                  in_data,
   input  logic [XLEN-1:0]                  in_r2,
   input  logic [XLEN-1:0]                  in_mul,
   input  logic                             in_isequal,
   input  logic                             in_f_mul,
   input  logic                             in_f_reg,
   input  logic                             in_f_jump,
   input  logic                             in_f_branch,
   input  logic                             in_f_iret,
   input  logic [1:0]                       in_f_tlbw,
   output logic                             redir_en,
   output logic [TID_W-1:0]                 redir_thread,
   output logic [XLEN-1:0]                  redir_pc,
   output logic [N_THREADS-1:0][XLEN-1:0]   rm0,
   output logic [N_THREADS-1:0][XLEN-1:0]   rm1,
   output logic [N_THREADS-1:0][XLEN-1:0]   rm2,
   output logic [N_THREADS-1:0]             rm4,
   output logic [N_THREADS-1:0]             rf_wen,
   output logic [REG_AW-1:0]                rf_addr,
   output logic [XLEN-1:0]                  rf_data,
   output logic                             itlb_wen,
   output logic                             dtlb_wen,
   output logic [VPN_W-1:0]                 tlb_vpn,
   output logic [PPN_W-1:0]                 tlb_ppn,
   output logic                             exc_en,
   output logic [TID_W-1:0]                 exc_thread,
   output logic [N_THREADS-1:0][31:0]       retire_cnt
);

   typedef enum logic {IDLE, EXC} state_t;

   state_t                           state_q;
   logic [TID_W-1:0]                 master_q;
   logic [N_THREADS-1:0][XLEN-1:0]   expect_pc_q;
   logic [N_THREADS-1:0][XLEN-1:0]   rm0_q, rm1_q, rm2_q;
   logic [N_THREADS-1:0]             rm4_q;
   logic                             redir_en_q;
   logic [TID_W-1:0]                 redir_thread_q;
   logic [XLEN-1:0]                  redir_pc_q;
   logic [N_THREADS-1:0]             rf_wen_q;
   logic [REG_AW-1:0]                rf_addr_q;
   logic [XLEN-1:0]                  rf_data_q;
   logic                             itlb_wen_q, dtlb_wen_q;
   logic [VPN_W-1:0]                 tlb_vpn_q;
   logic [PPN_W-1:0]                 tlb_ppn_q;

   logic             accept, inExc, fault, commit, iretTake, jumpTaken, doRedirect;
   logic [XLEN-1:0]  redir_pc_d, expect_pc_d;

   // Classify the presented instruction; stale PCs are ignored entirely.
   always_comb begin
      accept      = in_present && (in_pc == expect_pc_q[in_thread]);
      inExc       = (state_q == EXC);
      fault       = accept && !in_ok && !inExc && (in_itlb_miss || in_dtlb_miss);
      commit      = accept && in_ok && (!inExc || (in_thread == master_q));
      iretTake    = commit && in_f_iret && inExc;
      jumpTaken   = in_f_jump && (!in_f_branch || in_isequal);
      doRedirect  = 1'b0;
      redir_pc_d  = in_pc;
      expect_pc_d = in_pc + XLEN'(4);
      if (fault) begin
         doRedirect = 1'b1;
         redir_pc_d = EXC_PC;
      end else if (accept && !commit) begin
         doRedirect = 1'b1;
      end else if (iretTake) begin
         doRedirect  = 1'b1;
         redir_pc_d  = rm0_q[in_thread];
         expect_pc_d = rm0_q[in_thread];
      end else if (commit && jumpTaken) begin
         doRedirect  = 1'b1;
         redir_pc_d  = in_data;
         expect_pc_d = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         master_q       <= '0;
         rm0_q          <= '0;
         rm1_q          <= '0;
         rm2_q          <= '0;
         rm4_q          <= '0;
         redir_en_q     <= 1'b0;
         redir_thread_q <= '0;
         redir_pc_q     <= '0;
         rf_wen_q       <= '0;
         rf_addr_q      <= '0;
         rf_data_q      <= '0;
         itlb_wen_q     <= 1'b0;
         dtlb_wen_q     <= 1'b0;
         tlb_vpn_q      <= '0;
         tlb_ppn_q      <= '0;
         for (int i = 0; i < N_THREADS; i++) expect_pc_q[i] <= BOOT_PC;
      end else begin
         redir_en_q <= 1'b0;
         rf_wen_q   <= '0;
         itlb_wen_q <= 1'b0;
         dtlb_wen_q <= 1'b0;
         if (doRedirect) begin
            redir_en_q     <= 1'b1;
            redir_thread_q <= in_thread;
            redir_pc_q     <= redir_pc_d;
         end
         // An itlb miss wins over a dtlb miss when both are reported.
         if (fault) begin
            state_q                <= EXC;
            master_q               <= in_thread;
            rm0_q[in_thread]       <= in_pc;
            rm4_q[in_thread]       <= 1'b1;
            rm1_q[in_thread]       <= in_itlb_miss ? in_pc : in_data;
            rm2_q[in_thread]       <= in_itlb_miss ? XLEN'(1) : XLEN'(2);
            expect_pc_q[in_thread] <= EXC_PC;
         end
         if (commit) begin
            expect_pc_q[in_thread] <= expect_pc_d;
            if (in_f_reg) begin
               rf_wen_q  <= {{(N_THREADS-1){1'b0}}, 1'b1} << in_thread;
               rf_addr_q <= in_dst;
               rf_data_q <= in_f_mul ? in_mul : in_data;
            end
            if (in_f_tlbw == 2'b01 || in_f_tlbw == 2'b10) begin
               itlb_wen_q <= (in_f_tlbw == 2'b01);
               dtlb_wen_q <= (in_f_tlbw == 2'b10);
               tlb_vpn_q  <= in_data[VPN_W-1:0];
               tlb_ppn_q  <= in_r2[PPN_W-1:0];
            end
            if (iretTake) begin
               rm4_q[in_thread] <= 1'b0;
               state_q          <= IDLE;
            end
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [N_THREADS-1:0][31:0] retire_cnt_q;

   // Every commit retires, including an IRET that degenerates to a NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt_q <= '0;
      end else if (commit) begin
         retire_cnt_q[in_thread] <= retire_cnt_q[in_thread] + 32'd1;
      end
   end
   assign retire_cnt = retire_cnt_q;
`else
   assign retire_cnt = '0;
`endif

   logic unused_bits;
   assign unused_bits = ^in_r2;

   assign redir_en     = redir_en_q;
   assign redir_thread = redir_thread_q;
   assign redir_pc     = redir_pc_q;
   assign rm0          = rm0_q;
   assign rm1          = rm1_q;
   assign rm2          = rm2_q;
   assign rm4          = rm4_q;
   assign rf_wen       = rf_wen_q;
   assign rf_addr      = rf_addr_q;
   assign rf_data      = rf_data_q;
   assign itlb_wen     = itlb_wen_q;
   assign dtlb_wen     = dtlb_wen_q;
   assign tlb_vpn      = tlb_vpn_q;
   assign tlb_ppn      = tlb_ppn_q;
   assign exc_en       = (state_q == EXC);
   assign exc_thread   = master_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: a behavioural model pushes expected outputs per input,
// which are popped and compared one cycle later against the DUT.
module tb_wb_commit_unit;

   typedef struct packed {
      logic        present;
      logic [1:0]  thread;
      logic        ok, im, dm;
      logic [31:0] pc;
      logic [4:0]  dst;
      logic [31:0] data, r2, mul;
      logic        isequal, fmul, freg, fjump, fbranch, firet;
      logic [1:0]  tlbw;
   } InT;

   typedef struct packed {
      logic             redirEn;
      logic [1:0]       redirThread;
      logic [31:0]      redirPc;
      logic [3:0]       rfWen;
      logic [4:0]       rfAddr;
      logic [31:0]      rfData;
      logic             itlbWen, dtlbWen;
      logic [19:0]      vpn;
      logic [7:0]       ppn;
      logic             excEn;
      logic [1:0]       excThread;
      logic [3:0][31:0] rm0, rm1, rm2;
      logic [3:0]       rm4;
      logic [3:0][31:0] cnt;
   } ExpT;

   logic clk = 1'b0;
   logic rst;
   logic in_present, in_ok, in_itlb_miss, in_dtlb_miss;
   logic [1:0]  in_thread, in_f_tlbw;
   logic [31:0] in_pc, in_data, in_r2, in_mul;
   logic [4:0]  in_dst;
   logic in_isequal, in_f_mul, in_f_reg, in_f_jump, in_f_branch, in_f_iret;
   logic redir_en, itlb_wen, dtlb_wen, exc_en;
   logic [1:0]  redir_thread, exc_thread;
   logic [31:0] redir_pc, rf_data;
   logic [3:0][31:0] rm0, rm1, rm2, retire_cnt;
   logic [3:0]  rm4, rf_wen;
   logic [4:0]  rf_addr;
   logic [19:0] tlb_vpn;
   logic [7:0]  tlb_ppn;

   wb_commit_unit dut (
      .clk(clk), .rst(rst), .in_present(in_present), .in_thread(in_thread), .in_ok(in_ok),
      .in_itlb_miss(in_itlb_miss), .in_dtlb_miss(in_dtlb_miss), .in_pc(in_pc), .in_dst(in_dst),
      .in_data(in_data), .in_r2(in_r2), .in_mul(in_mul), .in_isequal(in_isequal),
      .in_f_mul(in_f_mul), .in_f_reg(in_f_reg), .in_f_jump(in_f_jump), .in_f_branch(in_f_branch),
      .in_f_iret(in_f_iret), .in_f_tlbw(in_f_tlbw), .redir_en(redir_en),
      .redir_thread(redir_thread), .redir_pc(redir_pc), .rm0(rm0), .rm1(rm1), .rm2(rm2),
      .rm4(rm4), .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data), .itlb_wen(itlb_wen),
      .dtlb_wen(dtlb_wen), .tlb_vpn(tlb_vpn), .tlb_ppn(tlb_ppn), .exc_en(exc_en),
      .exc_thread(exc_thread), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   int  compared = 0;
   int  mismatched = 0;
   ExpT expQ[$];
   ExpT mOut;
   logic [3:0][31:0] mExp;
   logic mState;
   logic [1:0] mMaster;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic compareAll();
      ExpT e;
      if (expQ.size() == 0) begin
         checkOutput("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = expQ.pop_front();
      checkOutput("redir_en", 64'(redir_en), 64'(e.redirEn));
      checkOutput("redir_thread", 64'(redir_thread), 64'(e.redirThread));
      checkOutput("redir_pc", 64'(redir_pc), 64'(e.redirPc));
      checkOutput("rf_wen", 64'(rf_wen), 64'(e.rfWen));
      checkOutput("rf_addr", 64'(rf_addr), 64'(e.rfAddr));
      checkOutput("rf_data", 64'(rf_data), 64'(e.rfData));
      checkOutput("itlb_wen", 64'(itlb_wen), 64'(e.itlbWen));
      checkOutput("dtlb_wen", 64'(dtlb_wen), 64'(e.dtlbWen));
      checkOutput("tlb_vpn", 64'(tlb_vpn), 64'(e.vpn));
      checkOutput("tlb_ppn", 64'(tlb_ppn), 64'(e.ppn));
      checkOutput("exc_en", 64'(exc_en), 64'(e.excEn));
      checkOutput("exc_thread", 64'(exc_thread), 64'(e.excThread));
      checkOutput("rm4", 64'(rm4), 64'(e.rm4));
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rm0[%0d]", i), 64'(rm0[i]), 64'(e.rm0[i]));
         checkOutput($sformatf("rm1[%0d]", i), 64'(rm1[i]), 64'(e.rm1[i]));
         checkOutput($sformatf("rm2[%0d]", i), 64'(rm2[i]), 64'(e.rm2[i]));
         checkOutput($sformatf("retire_cnt[%0d]", i), 64'(retire_cnt[i]), 64'(e.cnt[i]));
      end
   endtask

   // Reference behaviour: what the outputs must be one cycle after input s.
   task automatic modelStep(input InT s);
      logic t;
      mOut.redirEn = 1'b0;
      mOut.rfWen   = 4'b0;
      mOut.itlbWen = 1'b0;
      mOut.dtlbWen = 1'b0;
      if (s.present && s.pc == mExp[s.thread]) begin
         if (!s.ok) begin
            mOut.redirEn = 1'b1;
            mOut.redirThread = s.thread;
            if (!mState && (s.im || s.dm)) begin
               mState = 1'b1;
               mMaster = s.thread;
               mOut.rm0[s.thread] = s.pc;
               mOut.rm4[s.thread] = 1'b1;
               mOut.rm1[s.thread] = s.im ? s.pc : s.data;
               mOut.rm2[s.thread] = s.im ? 32'd1 : 32'd2;
               mOut.redirPc = 32'h2000;
               mExp[s.thread] = 32'h2000;
            end else begin
               mOut.redirPc = s.pc;
            end
         end else if (mState && s.thread != mMaster) begin
            mOut.redirEn = 1'b1;
            mOut.redirThread = s.thread;
            mOut.redirPc = s.pc;
         end else begin
`ifdef WB_RETIRE_CNT_EN
            mOut.cnt[s.thread] = mOut.cnt[s.thread] + 32'd1;
`endif
            mExp[s.thread] = s.pc + 32'd4;
            if (s.freg) begin
               mOut.rfWen = 4'b1 << s.thread;
               mOut.rfAddr = s.dst;
               mOut.rfData = s.fmul ? s.mul : s.data;
            end
            if (s.tlbw == 2'b01 || s.tlbw == 2'b10) begin
               mOut.itlbWen = (s.tlbw == 2'b01);
               mOut.dtlbWen = (s.tlbw == 2'b10);
               mOut.vpn = s.data[19:0];
               mOut.ppn = s.r2[7:0];
            end
            t = s.fjump && (!s.fbranch || s.isequal);
            if (s.firet && mState) begin
               mOut.redirEn = 1'b1;
               mOut.redirThread = s.thread;
               mOut.redirPc = mOut.rm0[s.thread];
               mExp[s.thread] = mOut.rm0[s.thread];
               mOut.rm4[s.thread] = 1'b0;
               mState = 1'b0;
            end else if (t) begin
               mOut.redirEn = 1'b1;
               mOut.redirThread = s.thread;
               mOut.redirPc = s.data;
               mExp[s.thread] = s.data;
            end
         end
      end
      mOut.excEn = mState;
      mOut.excThread = mMaster;
   endtask

   task automatic applyStimulus(input InT s);
      in_present = s.present; in_thread = s.thread; in_ok = s.ok;
      in_itlb_miss = s.im; in_dtlb_miss = s.dm; in_pc = s.pc; in_dst = s.dst;
      in_data = s.data; in_r2 = s.r2; in_mul = s.mul; in_isequal = s.isequal;
      in_f_mul = s.fmul; in_f_reg = s.freg; in_f_jump = s.fjump;
      in_f_branch = s.fbranch; in_f_iret = s.firet; in_f_tlbw = s.tlbw;
      modelStep(s);
      expQ.push_back(mOut);
      @(posedge clk);
      #1;
      compareAll();
   endtask

   task automatic resetDut();
      in_present = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mOut = '0;
      mState = 1'b0;
      mMaster = 2'd0;
      for (int i = 0; i < 4; i++) mExp[i] = 32'h1000;
      expQ.push_back(mOut);
      compareAll();
      rst = 1'b0;
   endtask

   function automatic InT mk(input logic [1:0] th, input logic [31:0] pc);
      InT s = '0;
      s.present = 1'b1;
      s.ok = 1'b1;
      s.thread = th;
      s.pc = pc;
      return s;
   endfunction

   initial begin
      InT s;
      in_present = 1'b0; in_thread = '0; in_ok = 1'b0; in_itlb_miss = 1'b0;
      in_dtlb_miss = 1'b0; in_pc = '0; in_dst = '0; in_data = '0; in_r2 = '0;
      in_mul = '0; in_isequal = 1'b0; in_f_mul = 1'b0; in_f_reg = 1'b0;
      in_f_jump = 1'b0; in_f_branch = 1'b0; in_f_iret = 1'b0; in_f_tlbw = 2'b00;
      resetDut();

      s = mk(0, 32'h1000); s.freg = 1; s.dst = 3; s.data = 32'h55; applyStimulus(s);
      checkOutput("first_alu_rf_data", 64'(rf_data), 64'h55);
      s = mk(1, 32'h1008); s.freg = 1; s.data = 32'h99; applyStimulus(s);
      s = mk(2, 32'h1000); s.ok = 0; s.im = 1; s.dm = 1; s.data = 32'h777; applyStimulus(s);
      checkOutput("fault_exc_thread", 64'(exc_thread), 64'd2);
      s = mk(0, 32'h1004); s.freg = 1; s.dst = 4; s.data = 32'h66; applyStimulus(s);
      s = mk(2, 32'h2000); s.tlbw = 2'b10; s.data = 32'h12345; s.r2 = 32'h7F; applyStimulus(s);
      s = mk(1, 32'h1000); s.ok = 0; s.dm = 1; applyStimulus(s);
      s = mk(2, 32'h2004); s.firet = 1; applyStimulus(s);
      checkOutput("iret_redir_pc", 64'(redir_pc), 64'h1000);
      s = mk(0, 32'h1004); s.freg = 1; s.fmul = 1; s.dst = 7; s.data = 32'h1; s.mul = 32'hDEAD;
      applyStimulus(s);
      s = mk(1, 32'h1000); s.ok = 0; s.dm = 1; s.data = 32'hBEEF000; applyStimulus(s);
      s = mk(1, 32'h2000); s.ok = 0; applyStimulus(s);
      s = mk(1, 32'h2000); s.tlbw = 2'b01; s.data = 32'hABCDE; s.r2 = 32'h33; applyStimulus(s);
      s = mk(1, 32'h2004); s.firet = 1; applyStimulus(s);
      s = mk(3, 32'h1000); s.firet = 1; applyStimulus(s);
      s = mk(3, 32'h1004); s.fjump = 1; s.fbranch = 1; s.data = 32'h4000; applyStimulus(s);
      s = mk(3, 32'h1008); s.fjump = 1; s.fbranch = 1; s.isequal = 1; s.data = 32'hFFFFFFFC;
      applyStimulus(s);
      s = mk(3, 32'hFFFFFFFC); s.freg = 1; s.dst = 9; s.data = 32'h7; applyStimulus(s);
      s = mk(3, 32'h0); s.freg = 1; s.dst = 10; s.data = 32'h8; s.tlbw = 2'b11; applyStimulus(s);
      s = mk(0, 32'h1008); s.ok = 0; applyStimulus(s);
      s = mk(0, 32'h1008); s.ok = 0; s.im = 1; applyStimulus(s);
      resetDut();

      for (int n = 0; n < 400; n++) begin
         s = mk(2'($urandom_range(0, 3)), 32'h0);
         if (mState && $urandom_range(0, 2) == 0) s.thread = mMaster;
         s.pc = ($urandom_range(0, 4) != 0) ? mExp[s.thread] : $urandom;
         s.present = ($urandom_range(0, 7) != 0);
         s.ok = ($urandom_range(0, 4) != 0);
         s.im = ($urandom_range(0, 3) == 0);
         s.dm = ($urandom_range(0, 3) == 0);
         s.dst = 5'($urandom);
         s.data = ($urandom_range(0, 1) != 0) ? 32'h1000 + 32'($urandom_range(0, 63)) * 4 : $urandom;
         s.r2 = $urandom;
         s.mul = $urandom;
         s.isequal = 1'($urandom);
         s.fmul = 1'($urandom);
         s.freg = 1'($urandom);
         s.fjump = ($urandom_range(0, 3) == 0);
         s.fbranch = 1'($urandom);
         s.firet = !s.fjump && ($urandom_range(0, 3) == 0);
         s.tlbw = 2'($urandom);
         applyStimulus(s);
         if (n == 200) resetDut();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
